// File: rtl/rf_pkg.sv
// Shared constants for the multi-port register bank and its read ports.
package rf_pkg;

    // Default geometry of the bank.
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    // Write port 1 has priority over write port 0 on an address collision.
    localparam int WR1_HI = 1;

    // Values for the ZERO_REG parameter.
    localparam int ZERO_REG_EN  = 1;
    localparam int ZERO_REG_DIS = 0;

endpackage : rf_pkg

// File: rtl/rf_read_port.sv
// One asynchronous read port: address decode, write-through bypass mux and
// ready flag derived from the scoreboard.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = ZERO_REG_DIS
) (
    input  logic             rst,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] stored,
    input  logic [DEPTH-1:0] pending,
    input  logic             wr0_en,
    input  logic [AW-1:0]    wr0_reg,
    input  logic [WIDTH-1:0] wr0_data,
    input  logic             wr1_en,
    input  logic [AW-1:0]    wr1_reg,
    input  logic [WIDTH-1:0] wr1_data,
    output logic [WIDTH-1:0] data,
    output logic             ready
);

    logic w_zero;
    logic w_hit0;
    logic w_hit1;

    // Bypass is disabled during reset so the read reflects the stored value.
    assign w_zero = (ZERO_REG != 0) && (addr == '0);
    assign w_hit1 = !rst && wr1_en && (wr1_reg == addr);
    assign w_hit0 = !rst && wr0_en && (wr0_reg == addr);

    // Read mux: hardwired zero, then high-priority write, then low, then storage.
    always_comb begin
        data = stored;
        if (w_zero) begin
            data = '0;
        end else if (w_hit1) begin
            data = wr1_data;
        end else if (w_hit0) begin
            data = wr0_data;
        end
    end

    // A register being written this cycle can be consumed through the bypass.
    assign ready = ~pending[addr] | w_hit1 | w_hit0;

endmodule : rf_read_port

// File: rtl/bank_register_mp.sv
// Register bank with two bypassed read ports, two prioritised write ports,
// synchronous clear, optional zero register and a per-register pending bit.
module bank_register_mp
    import rf_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = ZERO_REG_DIS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    src_reg,
    input  logic [AW-1:0]    dst_reg,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             a_ready,
    output logic             b_ready,
    input  logic             wr0_en,
    input  logic [AW-1:0]    wr0_reg,
    input  logic [WIDTH-1:0] wr0_data,
    input  logic             wr1_en,
    input  logic [AW-1:0]    wr1_reg,
    input  logic [WIDTH-1:0] wr1_data,
    input  logic             lock_en,
    input  logic [AW-1:0]    lock_reg,
    output logic [DEPTH-1:0] pending,
    output logic             wr_conflict
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pending_next;
    logic             w_wr0_ok;
    logic             w_wr1_ok;

    // Writes to the hardwired zero register are discarded.
    assign w_wr0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_reg == '0));
    assign w_wr1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_reg == '0));

    // Storage update; the higher-priority port is applied last so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (WR1_HI != 0) begin
            if (w_wr0_ok) r_mem[wr0_reg] <= wr0_data;
            if (w_wr1_ok) r_mem[wr1_reg] <= wr1_data;
        end else begin
            if (w_wr1_ok) r_mem[wr1_reg] <= wr1_data;
            if (w_wr0_ok) r_mem[wr0_reg] <= wr0_data;
        end
    end

    // Next scoreboard state per register: a fresh lock beats a retiring write.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                assign w_pending_next[gi] = 1'b0;
            end else begin : g_live
                logic w_lock_hit;
                logic w_wr_hit;
                assign w_lock_hit = lock_en && (lock_reg == AW'(gi));
                assign w_wr_hit   = (wr0_en && (wr0_reg == AW'(gi))) ||
                                    (wr1_en && (wr1_reg == AW'(gi)));
                assign w_pending_next[gi] = w_lock_hit ? 1'b1 :
                                            w_wr_hit   ? 1'b0 : r_pending[gi];
            end
        end
    endgenerate

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign pending     = r_pending;
    assign wr_conflict = wr0_en & wr1_en & (wr0_reg == wr1_reg);

    rf_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)
    ) u_port_a (
        .rst(rst), .addr(src_reg), .stored(r_mem[src_reg]), .pending(r_pending),
        .wr0_en(wr0_en), .wr0_reg(wr0_reg), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_reg(wr1_reg), .wr1_data(wr1_data),
        .data(a), .ready(a_ready)
    );

    rf_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)
    ) u_port_b (
        .rst(rst), .addr(dst_reg), .stored(r_mem[dst_reg]), .pending(r_pending),
        .wr0_en(wr0_en), .wr0_reg(wr0_reg), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_reg(wr1_reg), .wr1_data(wr1_data),
        .data(b), .ready(b_ready)
    );

endmodule : bank_register_mp

// File: tb/tb_bank_register_mp.sv
// Directed bench for bank_register_mp: one instance without and one with the
// hardwired zero register, both driven by the same stimulus.
module tb_bank_register_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_reg, dst_reg, wr0_reg, wr1_reg, lock_reg;
    logic        wr0_en, wr1_en, lock_en;
    logic [15:0] wr0_data, wr1_data;

    logic [15:0] a0, b0, a1, b1;
    logic        a_ready0, b_ready0, a_ready1, b_ready1;
    logic [15:0] pending0, pending1;
    logic        wr_conflict0, wr_conflict1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bank_register_mp #(.WIDTH(16), .DEPTH(16), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .src_reg(src_reg), .dst_reg(dst_reg),
        .a(a0), .b(b0), .a_ready(a_ready0), .b_ready(b_ready0),
        .wr0_en(wr0_en), .wr0_reg(wr0_reg), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_reg(wr1_reg), .wr1_data(wr1_data),
        .lock_en(lock_en), .lock_reg(lock_reg),
        .pending(pending0), .wr_conflict(wr_conflict0)
    );

    bank_register_mp #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .src_reg(src_reg), .dst_reg(dst_reg),
        .a(a1), .b(b1), .a_ready(a_ready1), .b_ready(b_ready1),
        .wr0_en(wr0_en), .wr0_reg(wr0_reg), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_reg(wr1_reg), .wr1_data(wr1_data),
        .lock_en(lock_en), .lock_reg(lock_reg),
        .pending(pending1), .wr_conflict(wr_conflict1)
    );

    // Advance one edge; inputs change 1 ns after it, checks happen 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr1_en = 1'b0; lock_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        // Load R5 and lock it, then reset with a write to R6 in the same cycle.
        wr0_en = 1'b1; wr0_reg = 4'd5; wr0_data = 16'h1234;
        lock_en = 1'b1; lock_reg = 4'd5;
        tick(); idle();
        src_reg = 4'd5;
        #1;
        tests_run++;
        if (a0 !== 16'h1234) begin tests_failed++; $display("FAIL reset_preload a=%h exp=%h", a0, 16'h1234); end
        tests_run++;
        if (pending0 !== 16'h0020) begin tests_failed++; $display("FAIL reset_prelock pending=%h exp=%h", pending0, 16'h0020); end
        rst = 1'b1;
        wr1_en = 1'b1; wr1_reg = 4'd6; wr1_data = 16'h7777;
        dst_reg = 4'd6;
        #1;
        tests_run++;
        if (b0 !== 16'h0000) begin tests_failed++; $display("FAIL reset_no_bypass b=%h exp=%h", b0, 16'h0000); end
        tick();
        rst = 1'b0; idle();
        #1;
        tests_run++;
        if (a0 !== 16'h0000 || b0 !== 16'h0000) begin tests_failed++; $display("FAIL reset_data a=%h b=%h exp=0000/0000", a0, b0); end
        tests_run++;
        if (pending0 !== 16'h0000 || pending1 !== 16'h0000) begin tests_failed++; $display("FAIL reset_pending p0=%h p1=%h exp=0000", pending0, pending1); end
        tests_run++;
        if (a_ready0 !== 1'b1 || b_ready0 !== 1'b1) begin tests_failed++; $display("FAIL reset_ready a_rdy=%b b_rdy=%b exp=1/1", a_ready0, b_ready0); end
        $display("[TB] reset: a=%h b=%h pending=%h", a0, b0, pending0);
    endtask

    task automatic test_basic();
        wr0_en = 1'b1; wr0_reg = 4'd3; wr0_data = 16'hBEEF;
        wr1_en = 1'b1; wr1_reg = 4'd7; wr1_data = 16'h0042;
        src_reg = 4'd3; dst_reg = 4'd7;
        #1;
        tests_run++;
        if (wr_conflict0 !== 1'b0) begin tests_failed++; $display("FAIL basic_no_conflict wr_conflict=%b exp=0", wr_conflict0); end
        tick(); idle();
        tests_run++;
        if (a0 !== 16'hBEEF || a1 !== 16'hBEEF) begin tests_failed++; $display("FAIL basic_a a0=%h a1=%h exp=%h", a0, a1, 16'hBEEF); end
        tests_run++;
        if (b0 !== 16'h0042 || b1 !== 16'h0042) begin tests_failed++; $display("FAIL basic_b b0=%h b1=%h exp=%h", b0, b1, 16'h0042); end
        $display("[TB] basic: R3=%h R7=%h", a0, b0);
    endtask

    task automatic test_priority();
        wr0_en = 1'b1; wr0_reg = 4'd4; wr0_data = 16'h1111;
        wr1_en = 1'b1; wr1_reg = 4'd4; wr1_data = 16'h2222;
        src_reg = 4'd4; dst_reg = 4'd3;
        #1;
        tests_run++;
        if (a0 !== 16'h2222) begin tests_failed++; $display("FAIL prio_bypass a=%h exp=%h", a0, 16'h2222); end
        tests_run++;
        if (wr_conflict0 !== 1'b1) begin tests_failed++; $display("FAIL prio_conflict wr_conflict=%b exp=1", wr_conflict0); end
        tests_run++;
        if (b0 !== 16'hBEEF) begin tests_failed++; $display("FAIL prio_other_port b=%h exp=%h", b0, 16'hBEEF); end
        // Only wr0 to R4 bypasses the low-priority data.
        wr1_reg = 4'd8;
        #1;
        tests_run++;
        if (a0 !== 16'h1111) begin tests_failed++; $display("FAIL prio_wr0_bypass a=%h exp=%h", a0, 16'h1111); end
        wr1_reg = 4'd4;
        #1;
        tick(); idle();
        tests_run++;
        if (a0 !== 16'h2222) begin tests_failed++; $display("FAIL prio_stored a=%h exp=%h", a0, 16'h2222); end
        $display("[TB] priority: R4=%h", a0);
    endtask

    task automatic test_scoreboard();
        lock_en = 1'b1; lock_reg = 4'd9;
        src_reg = 4'd9; dst_reg = 4'd9;
        tick(); idle();
        tests_run++;
        if (pending0 !== 16'h0200 || a_ready0 !== 1'b0 || b_ready0 !== 1'b0) begin
            tests_failed++; $display("FAIL sb_lock pending=%h a_rdy=%b b_rdy=%b exp=0200/0/0", pending0, a_ready0, b_ready0);
        end
        // Re-lock of a pending register leaves it pending.
        lock_en = 1'b1;
        tick(); idle();
        tests_run++;
        if (pending0 !== 16'h0200) begin tests_failed++; $display("FAIL sb_relock pending=%h exp=%h", pending0, 16'h0200); end
        wr0_en = 1'b1; wr0_reg = 4'd9; wr0_data = 16'h00AA;
        #1;
        tests_run++;
        if (a_ready0 !== 1'b1 || a0 !== 16'h00AA) begin tests_failed++; $display("FAIL sb_write_ready a_rdy=%b a=%h exp=1/00aa", a_ready0, a0); end
        tick(); idle();
        tests_run++;
        if (pending0 !== 16'h0000 || a_ready0 !== 1'b1 || a0 !== 16'h00AA) begin
            tests_failed++; $display("FAIL sb_clear pending=%h a_rdy=%b a=%h exp=0000/1/00aa", pending0, a_ready0, a0);
        end
        $display("[TB] scoreboard: pending=%h R9=%h", pending0, a0);
    endtask

    task automatic test_lock_write();
        lock_en = 1'b1; lock_reg = 4'd2;
        wr1_en = 1'b1; wr1_reg = 4'd2; wr1_data = 16'h5555;
        src_reg = 4'd2;
        #1;
        tests_run++;
        if (a_ready0 !== 1'b1 || a0 !== 16'h5555) begin tests_failed++; $display("FAIL lw_same_cycle a_rdy=%b a=%h exp=1/5555", a_ready0, a0); end
        tick(); idle();
        tests_run++;
        if (a0 !== 16'h5555 || pending0 !== 16'h0004 || a_ready0 !== 1'b0) begin
            tests_failed++; $display("FAIL lw_result a=%h pending=%h a_rdy=%b exp=5555/0004/0", a0, pending0, a_ready0);
        end
        $display("[TB] lock+write: R2=%h pending=%h", a0, pending0);
    endtask

    task automatic test_zero_reg();
        wr1_en = 1'b1; wr1_reg = 4'd0; wr1_data = 16'hFFFF;
        lock_en = 1'b1; lock_reg = 4'd0;
        src_reg = 4'd0;
        #1;
        tests_run++;
        if (a1 !== 16'h0000 || a0 !== 16'hFFFF) begin tests_failed++; $display("FAIL zero_bypass a1=%h a0=%h exp=0000/ffff", a1, a0); end
        tick(); idle();
        tests_run++;
        if (a1 !== 16'h0000 || pending1 !== 16'h0004 || a_ready1 !== 1'b1) begin
            tests_failed++; $display("FAIL zero_on a=%h pending=%h a_rdy=%b exp=0000/0004/1", a1, pending1, a_ready1);
        end
        tests_run++;
        if (a0 !== 16'hFFFF || pending0 !== 16'h0005 || a_ready0 !== 1'b0) begin
            tests_failed++; $display("FAIL zero_off a=%h pending=%h a_rdy=%b exp=ffff/0005/0", a0, pending0, a_ready0);
        end
        $display("[TB] zero_reg: R0 zr=%h nozr=%h", a1, a0);
    endtask

    initial begin
        rst = 1'b1;
        src_reg = '0; dst_reg = '0; wr0_reg = '0; wr1_reg = '0; lock_reg = '0;
        wr0_en = 1'b0; wr1_en = 1'b0; lock_en = 1'b0;
        wr0_data = '0; wr1_data = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_priority();
        test_scoreboard();
        test_lock_write();
        test_zero_reg();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_bank_register_mp

// File: doc/bank_register_mp.md
Name: bank_register_mp

Overview:
Parametrised successor to the single-write, two-read general register bank that feeds the ALU. It provides:
- DEPTH x WIDTH storage.
- Two asynchronous read ports with same-cycle write-through bypass.
- Two synchronous write ports with fixed priority.
- Synchronous clear of all storage.
- An optional hardwired zero register.
- A per-register pending (scoreboard) bit, so the control unit can stall reads of registers whose results are not yet written back.

Parameters:
WIDTH, 16, data width of each register
DEPTH, 16, number of registers; must be a power of two, at least 2
AW, $clog2(DEPTH), register address width (derived, do not override)
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes and locks

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
src_reg  in  AW  read address, port A
dst_reg  in  AW  read address, port B
a  out  WIDTH  read data, port A
b  out  WIDTH  read data, port B
a_ready  out  1  1 = src_reg not pending
b_ready  out  1  1 = dst_reg not pending
wr0_en  in  1  write enable, port 0 (low priority)
wr0_reg  in  AW  write address, port 0
wr0_data  in  WIDTH  write data, port 0
wr1_en  in  1  write enable, port 1 (high priority)
wr1_reg  in  AW  write address, port 1
wr1_data  in  WIDTH  write data, port 1
lock_en  in  1  mark lock_reg pending (instruction issue)
lock_reg  in  AW  register to mark pending
pending  out  DEPTH  scoreboard vector, bit i = register i pending
wr_conflict  out  1  both write ports target the same register this cycle

Behaviour:
- Reset:
  - rst high at a rising edge clears all registers and all pending bits to 0.
  - Writes and locks in that cycle are ignored.
  - After reset: a = b = 0, a_ready = b_ready = 1, pending = 0.
- Writes:
  - Take effect at the rising edge; latency 1.
  - If wr0_en and wr1_en target the same register, wr1_data is stored and wr0 is dropped.
  - wr_conflict is combinational: wr0_en & wr1_en & (wr0_reg == wr1_reg), otherwise 0. It is diagnostic only.
- Reads:
  - Combinational, 0-cycle latency.
  - Bypass priority: (1) ZERO_REG=1 and address 0 -> 0; (2) wr1 hit -> wr1_data; (3) wr0 hit -> wr0_data; (4) stored value.
  - Bypass is suppressed while rst = 1; the read returns the stored value instead.
- Pending bits:
  - Set at the edge by lock_en on lock_reg.
  - Cleared at the edge by any enabled write to that register.
  - Lock and write to the same register in the same cycle: the lock wins and the bit ends at 1, because a new producer has been issued. The data is still written.
  - Lock of an already pending register: no change.
  - ZERO_REG=1: bit 0 is hardwired to 0.
- Ready flags:
  - a_ready = ~pending[src_reg] | bypass hit on src_reg; b_ready is the same for dst_reg.
  - So a register being written this cycle reads as ready, unless it is also locked this cycle: ready then follows the bypass, and pending goes high next cycle.
- Address range: no out-of-range addresses exist, since DEPTH = 2^AW.
- All state updates happen on the clk edge only; no latches.

Decomposition:
- Shared package rf_pkg holds:
  - default WIDTH/DEPTH constants;
  - a priority encoding constant (WR1_HI = 1);
  - the ZERO_REG_EN / ZERO_REG_DIS constants.
- One sub-module is natural: rf_read_port. It contains the address decode, bypass mux and ready logic, and is instantiated twice, for A and B.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset: write R5=16'h1234, assert rst one cycle -> a(src=5) = 0, pending = 0, a_ready = 1. Also: a write issued in the reset cycle is ignored.
- Basic write/read: wr0 R3=16'hBEEF -> next cycle a(src=3) = 16'hBEEF. Same cycle, wr1 R7=16'h0042 -> b(dst=7) = 16'h0042.
- Bypass and priority: same cycle, wr0 R4=16'h1111, wr1 R4=16'h2222, src=4 -> a = 16'h2222 combinationally and wr_conflict = 1. Next cycle a = 16'h2222.
- Scoreboard: lock R9 -> pending[9] = 1 and a_ready(src=9) = 0. Later, wr0 R9=16'h00AA -> a_ready = 1 in that cycle and pending[9] = 0 after the edge.
- Lock and write collide: lock R2 and wr1 R2=16'h5555 in the same cycle -> R2 = 16'h5555 and pending[2] = 1.
- ZERO_REG=1: wr1 R0=16'hFFFF and lock R0 -> a(src=0) = 0, pending[0] = 0, a_ready = 1. With ZERO_REG=0, the same stimulus -> R0 = 16'hFFFF.
